// File: rtl/wb_queue_if.sv
// Bundle of handshake, register-file write and hazard-query signals around wb_queue.
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface wb_queue_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_rd_wen;
    logic                  in_is_load;
    logic [1:0]            in_ld_size;
    logic                  in_ld_unsigned;
    logic [DATA_WIDTH-1:0] in_result;
    logic                  wb_stall;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rs1_pending;
    logic                  rs2_pending;
    logic                  empty;

    modport slave (
        input  in_valid, in_rd, in_rd_wen, in_is_load, in_ld_size, in_ld_unsigned, in_result,
        input  wb_stall, rs1_addr, rs2_addr,
        output in_ready, wen, waddr, wdata, rs1_pending, rs2_pending, empty
    );

    modport master (
        output in_valid, in_rd, in_rd_wen, in_is_load, in_ld_size, in_ld_unsigned, in_result,
        output wb_stall, rs1_addr, rs2_addr,
        input  in_ready, wen, waddr, wdata, rs1_pending, rs2_pending, empty
    );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back FIFO feeding the integer register file, with load extension at push.
// Optional macro WB_QUEUE_RETIRE_CNT_EN adds a 64-bit retire_cnt output counting every pop.
module wb_queue #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_queue_if.slave   bus
`ifdef WB_QUEUE_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      wen_q;
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  is_empty, is_full, push, pop;
    logic                  ext_sign;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  rs1_hit, rs2_hit;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign push     = bus.in_valid && !is_full;
    assign pop      = !is_empty && !bus.wb_stall;

    always_comb begin
        ext_sign = 1'b0;
        ext_data = bus.in_result;
        if (bus.in_is_load) begin
            case (bus.in_ld_size)
                2'b00: begin
                    ext_sign = !bus.in_ld_unsigned && bus.in_result[7];
                    ext_data = {{(DATA_WIDTH-8){ext_sign}}, bus.in_result[7:0]};
                end
                2'b01: begin
                    ext_sign = !bus.in_ld_unsigned && bus.in_result[15];
                    ext_data = {{(DATA_WIDTH-16){ext_sign}}, bus.in_result[15:0]};
                end
                2'b10: begin
                    ext_sign = !bus.in_ld_unsigned && bus.in_result[31];
                    ext_data = {{(DATA_WIDTH-32){ext_sign}}, bus.in_result[31:0]};
                end
                default: ext_data = bus.in_result;
            endcase
        end
    end

    // Payload needs no reset: valid_q/count_q gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= bus.in_rd;
            data_q[wr_ptr_q] <= ext_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            wen_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wen_q[wr_ptr_q]   <= bus.in_rd_wen && (bus.in_rd != '0);
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && wen_q[i] && (rd_q[i] == bus.rs1_addr)) rs1_hit = 1'b1;
            if (valid_q[i] && wen_q[i] && (rd_q[i] == bus.rs2_addr)) rs2_hit = 1'b1;
        end
    end

    assign bus.in_ready    = !is_full;
    assign bus.empty       = is_empty;
    assign bus.wen         = pop && wen_q[rd_ptr_q];
    assign bus.waddr       = is_empty ? '0 : rd_q[rd_ptr_q];
    assign bus.wdata       = is_empty ? '0 : data_q[rd_ptr_q];
    assign bus.rs1_pending = rs1_hit && (bus.rs1_addr != '0);
    assign bus.rs2_pending = rs2_hit && (bus.rs2_addr != '0);

`ifdef WB_QUEUE_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (pop) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a queue-based reference model checked every cycle, plus literal
// spot checks on the scenarios of interest.
module tb_wb_queue;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    wb_queue_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();
`ifdef WB_QUEUE_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    wb_queue #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef WB_QUEUE_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of pending writes in program order.
    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;
    } ent_t;
    ent_t        mq[$];
    logic [63:0] m_retire;

    function automatic logic [63:0] extend(input logic ld, input logic [1:0] sz, input logic uns,
                                           input logic [63:0] r);
        int unsigned bits;
        logic [63:0] mask;
        logic [63:0] v;
        if (!ld || sz == 2'b11) return r;
        bits = 8 << sz;
        mask = (64'd1 << bits) - 64'd1;
        v = r & mask;
        if (!uns && r[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic pending(input logic [4:0] a);
        foreach (mq[i]) if (mq[i].wen && mq[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit do_pop, do_push;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_retire = '0;
        end else begin
            do_pop  = (mq.size() > 0) && !bus.wb_stall;
            do_push = bus.in_valid && (mq.size() < DEPTH);
            if (do_pop) begin
                void'(mq.pop_front());
                m_retire = m_retire + 64'd1;
            end
            if (do_push) begin
                e.rd   = bus.in_rd;
                e.wen  = bus.in_rd_wen && (bus.in_rd != 5'd0);
                e.data = extend(bus.in_is_load, bus.in_ld_size, bus.in_ld_unsigned, bus.in_result);
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        bit ne;
        ne = mq.size() > 0;
        check("in_ready", bus.in_ready, mq.size() < DEPTH);
        check("empty", bus.empty, !ne);
        check("wen", bus.wen, ne && !bus.wb_stall && mq[0].wen);
        check("waddr", bus.waddr, ne ? mq[0].rd : 5'd0);
        check("wdata", bus.wdata, ne ? mq[0].data : 64'd0);
        check("rs1_pending", bus.rs1_pending, bus.rs1_addr != 0 && pending(bus.rs1_addr));
        check("rs2_pending", bus.rs2_pending, bus.rs2_addr != 0 && pending(bus.rs2_addr));
`ifdef WB_QUEUE_RETIRE_CNT_EN
        check("retire_cnt", retire_cnt, m_retire);
`endif
    end

    task automatic push(input logic [4:0] rd, input logic we, input logic ld,
                        input logic [1:0] sz, input logic uns, input logic [63:0] d);
        bus.in_rd          = rd;
        bus.in_rd_wen      = we;
        bus.in_is_load     = ld;
        bus.in_ld_size     = sz;
        bus.in_ld_unsigned = uns;
        bus.in_result      = d;
        bus.in_valid       = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 0; bus.in_rd = 0; bus.in_rd_wen = 0; bus.in_is_load = 0;
        bus.in_ld_size = 0; bus.in_ld_unsigned = 0; bus.in_result = 0; bus.wb_stall = 0;
        bus.rs1_addr = 0; bus.rs2_addr = 0;
        #2;
        check("rst_empty", bus.empty, 1'b1);
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_wen", bus.wen, 1'b0);
        check("rst_waddr", bus.waddr, 5'd0);
        check("rst_wdata", bus.wdata, 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Single ALU result, written one edge after acceptance.
        push(5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 64'h1234);
        check("alu_wen", bus.wen, 1'b1);
        check("alu_waddr", bus.waddr, 5'd5);
        check("alu_wdata", bus.wdata, 64'h1234);
        @(posedge clk); #1;
        check("alu_drained", bus.empty, 1'b1);

        // Load extension, back-to-back (push and pop share each edge).
        push(5'd3, 1'b1, 1'b1, 2'b00, 1'b0, 64'h80F0);
        check("lb", bus.wdata, 64'hFFFF_FFFF_FFFF_FFF0);
        push(5'd3, 1'b1, 1'b1, 2'b00, 1'b1, 64'h80F0);
        check("lbu", bus.wdata, 64'h0000_0000_0000_00F0);
        push(5'd3, 1'b1, 1'b1, 2'b01, 1'b0, 64'h80F0);
        check("lh", bus.wdata, 64'hFFFF_FFFF_FFFF_80F0);
        push(5'd3, 1'b1, 1'b1, 2'b01, 1'b1, 64'h80F0);
        check("lhu", bus.wdata, 64'h0000_0000_0000_80F0);
        push(5'd3, 1'b1, 1'b1, 2'b10, 1'b0, 64'h80F0);
        check("lw_pos", bus.wdata, 64'h0000_0000_0000_80F0);
        push(5'd3, 1'b1, 1'b1, 2'b10, 1'b0, 64'h1234_5678_8000_0001);
        check("lw_neg", bus.wdata, 64'hFFFF_FFFF_8000_0001);
        push(5'd3, 1'b1, 1'b1, 2'b11, 1'b0, 64'h8000_0000_0000_00FF);
        check("ld", bus.wdata, 64'h8000_0000_0000_00FF);
        push(5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 64'hFFFF_0000_0000_0080);
        check("noload", bus.wdata, 64'hFFFF_0000_0000_0080);
        @(posedge clk); #1;

        // Full under stall; third push waits until a slot frees.
        bus.wb_stall = 1'b1;
        push(5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 64'h11);
        push(5'd2, 1'b1, 1'b0, 2'b00, 1'b0, 64'h22);
        check("full_ready", bus.in_ready, 1'b0);
        bus.in_rd = 5'd3; bus.in_result = 64'h33; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check("full_refused", bus.in_ready, 1'b0);
        check("stall_wen", bus.wen, 1'b0);
        bus.wb_stall = 1'b0;
        #1;
        check("drain1_wen", bus.wen, 1'b1);
        check("drain1_waddr", bus.waddr, 5'd1);
        @(posedge clk); #1;
        check("drain2_waddr", bus.waddr, 5'd2);
        check("drain2_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("third_waddr", bus.waddr, 5'd3);
        check("third_wdata", bus.wdata, 64'h33);
        @(posedge clk); #1;
        check("full_done", bus.empty, 1'b1);

        // x0 and no-write entries never raise wen.
        bus.rs1_addr = 5'd0;
        push(5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 64'h55);
        check("x0_wen", bus.wen, 1'b0);
        check("x0_empty", bus.empty, 1'b0);
        check("x0_pending", bus.rs1_pending, 1'b0);
        push(5'd6, 1'b0, 1'b0, 2'b00, 1'b0, 64'h66);
        check("nowrite_wen", bus.wen, 1'b0);
        @(posedge clk); #1;

        // Pending tracks queued rd=7 until the cycle after drain.
        bus.wb_stall = 1'b1; bus.rs2_addr = 5'd7;
        bus.in_rd = 5'd7; bus.in_rd_wen = 1'b1; bus.in_is_load = 1'b0; bus.in_valid = 1'b1;
        #1;
        check("pend_not_incoming", bus.rs2_pending, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("pend_queued", bus.rs2_pending, 1'b1);
        @(posedge clk); #1;
        check("pend_stalled", bus.rs2_pending, 1'b1);
        bus.wb_stall = 1'b0;
        #1;
        check("pend_draining", bus.rs2_pending, 1'b1);
        check("pend_waddr", bus.waddr, 5'd7);
        @(posedge clk); #1;
        check("pend_cleared", bus.rs2_pending, 1'b0);

        // Asynchronous reset with two entries queued.
        bus.wb_stall = 1'b1;
        push(5'd9, 1'b1, 1'b0, 2'b00, 1'b0, 64'h99);
        push(5'd10, 1'b1, 1'b0, 2'b00, 1'b0, 64'hAA);
        bus.rs1_addr = 5'd9;
        #1;
        check("pre_rst_pending", bus.rs1_pending, 1'b1);
        bus.wb_stall = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_wen", bus.wen, 1'b0);
        check("mid_rst_empty", bus.empty, 1'b1);
        check("mid_rst_ready", bus.in_ready, 1'b1);
        check("mid_rst_pending", bus.rs1_pending, 1'b0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("post_rst_wen", bus.wen, 1'b0);
        end

        // Five pops including an x0 entry.
        push(5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 64'h1);
        push(5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 64'h2);
        push(5'd2, 1'b1, 1'b1, 2'b00, 1'b0, 64'h83);
        check("ret_lb", bus.wdata, 64'hFFFF_FFFF_FFFF_FF83);
        push(5'd3, 1'b0, 1'b0, 2'b00, 1'b0, 64'h4);
        push(5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 64'h5);
        @(posedge clk); #1;
        check("ret_empty", bus.empty, 1'b1);
`ifdef WB_QUEUE_RETIRE_CNT_EN
        check("retire_5", retire_cnt, 64'd5);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back stage directly upstream of the integer register file. Accepts completed instructions from the LSU/EXU via a valid/ready handshake and buffers them in a small in-order FIFO.
- Applies load sign/zero extension, then drains one entry per cycle into the register file write port (wen/waddr/wdata).
- Reports pending writes per source register so the issue logic can stall on RAW hazards.

Parameters:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 64, register/data width.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  queue can accept; equals !full
- in_rd  input  ADDR_WIDTH  destination register
- in_rd_wen  input  1  instruction writes rd
- in_is_load  input  1  result is raw load data needing extension
- in_ld_size  input  2  00 byte, 01 half, 10 word, 11 double
- in_ld_unsigned  input  1  zero-extend when 1, sign-extend when 0
- in_result  input  DATA_WIDTH  ALU result or raw load data (LSB-aligned)
- wb_stall  input  1  hold queue head; no drain this cycle
- wen  output  1  register file write enable
- waddr  output  ADDR_WIDTH  register file write address
- wdata  output  DATA_WIDTH  register file write data
- rs1_addr  input  ADDR_WIDTH  issue-stage source 1 index
- rs2_addr  input  ADDR_WIDTH  issue-stage source 2 index
- rs1_pending  output  1  a queued entry will write rs1
- rs2_pending  output  1  a queued entry will write rs2
- empty  output  1  no valid entries

Behaviour:
- Reset (async, rst=1): all entry valid bits cleared; rd pointer and wr pointer set to 0; count set to 0.
- Outputs during reset: wen=0, empty=1, in_ready=1, rs*_pending=0. waddr/wdata = 0.
- Push: in_valid && in_ready at posedge. Entry stores rd, an effective wen, and extended data.
  - Effective wen = in_rd_wen && (in_rd != 0). Writes to x0 are queued but never asserted on wen.
- Extension is applied at push time, only when in_is_load=1.
  - Size 00 extends bits [7:0]; 01 extends [15:0]; 10 extends [31:0]; 11 passes through unchanged.
  - Sign vs zero extension is selected by in_ld_unsigned.
  - When in_is_load=0, in_result is stored unmodified.
- Pop: occurs at posedge when !empty && !wb_stall.
  - wen/waddr/wdata are driven combinationally from the head entry: wen = !empty && !wb_stall && head.wen.
  - The regfile latches on the same edge as the pop.
  - Latency: accepted at edge N, written to the regfile at edge N+1 when there is no stall.
- Full: count==DEPTH, so in_ready=0. A simultaneous pop does not free the slot in the same cycle; there is no pass-through.
- Empty: wen=0. Pop is suppressed, and the pointers do not move.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- rsN_pending = OR over valid entries of (entry.wen && entry.rd == rsN_addr).
  - Always 0 when rsN_addr==0.
  - Purely combinational; it does not include the entry being pushed this cycle.
- Upstream must hold in_* stable while in_valid && !in_ready. Behaviour when this is violated is unspecified.

Optional Feature:
- Macro: WB_QUEUE_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt (64-bit), which increments by 1 on every pop, including x0/no-write entries.
  - Reset value 0; wraps at 2^64.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-operation: two entries queued, then rst=1 asynchronously → wen=0, empty=1, in_ready=1 immediately. After release, no stale writes occur.
- Single ALU result: push rd=5, in_result=0x1234, in_rd_wen=1 → next cycle wen=1, waddr=5, wdata=0x1234. Then empty=1.
- Load extension: in_result=0x00000000_000080F0.
  - size=00, signed → wdata=0xFFFFFFFF_FFFFFFF0.
  - size=00, unsigned → 0xF0.
  - size=01, signed → 0xFFFFFFFF_FFFF80F0.
  - size=10, signed → 0x80F0.
- Full and stall: wb_stall=1, push rd=1 then rd=2 → in_ready=0, a third push is refused. Release stall → waddr=1 then waddr=2 on consecutive cycles, and the third item is accepted once not full.
- x0 and pending:
  - Push rd=0 with in_rd_wen=1 → wen stays 0 on drain; rs1_addr=0 gives rs1_pending=0.
  - Push rd=7 under stall with rs2_addr=7 → rs2_pending=1 until the cycle after drain.
- With WB_QUEUE_RETIRE_CNT_EN: 5 pops, including one x0 entry → retire_cnt=5.
